// File: rtl/buffer_load_sequencer_pkg.sv
// Shared definitions for the NPU layer-pass sequencer: FSM encoding and default sizes.
package buffer_load_sequencer_pkg;

   localparam int DEF_DATA_W       = 32;
   localparam int DEF_INPUT_WORDS  = 16;
   localparam int DEF_WEIGHT_WORDS = 16;
   localparam int DEF_INDEX_WORDS  = 8;
   localparam int DEF_OUTPUT_WORDS = 16;
   localparam int DEF_CNT_W        = 16;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD_IN  = 3'd1,
      ST_LOAD_WT  = 3'd2,
      ST_LOAD_IDX = 3'd3,
      ST_COMPUTE  = 3'd4,
      ST_DRAIN    = 3'd5
   } state_t;

endpackage

// File: rtl/buffer_load_sequencer_if.sv
// Valid/ready word stream used for both the host input and host output ports.
interface buffer_load_sequencer_if
   import buffer_load_sequencer_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
);
   logic [DATA_W-1:0] data;
   logic              valid;
   logic              ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/buffer_load_sequencer_seg_counter.sv
// Clearable up-counter with an equality compare against a run-time limit.
module buffer_load_sequencer_seg_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             inc,
   input  logic [CNT_W-1:0] limit,
   output logic             hit
);
   logic [CNT_W-1:0] count;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)      count <= '0;
      else if (clear) count <= '0;
      else if (inc)   count <= count + 1'b1;
   end

   assign hit = (count == limit);
endmodule

// File: rtl/buffer_load_sequencer.sv
// Layer-pass controller: loads input/weight/index buffers from one stream, kicks compute, drains output.
module buffer_load_sequencer
   import buffer_load_sequencer_pkg::*;
#(
   parameter int DATA_W       = DEF_DATA_W,
   parameter int INPUT_WORDS  = DEF_INPUT_WORDS,
   parameter int WEIGHT_WORDS = DEF_WEIGHT_WORDS,
   parameter int INDEX_WORDS  = DEF_INDEX_WORDS,
   parameter int OUTPUT_WORDS = DEF_OUTPUT_WORDS,
   parameter int CNT_W        = DEF_CNT_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   buffer_load_sequencer_if.slave  s,
   output logic                 in_wr_en,
   output logic                 wt_wr_en,
   output logic                 idx_wr_en,
   output logic [DATA_W-1:0]    buf_wr_data,
   output logic                 compute_start,
   input  logic                 compute_done,
   output logic                 out_rd_en,
   input  logic [DATA_W-1:0]    out_rd_data,
   buffer_load_sequencer_if.master m,
   output logic                 busy,
   output logic                 done
);
   // Load and send counters compare against the last index; the read counter against the total.
   localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(INPUT_WORDS - 1);
   localparam logic [CNT_W-1:0] WT_LAST  = CNT_W'(WEIGHT_WORDS - 1);
   localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(INDEX_WORDS - 1);
   localparam logic [CNT_W-1:0] OUT_ALL  = CNT_W'(OUTPUT_WORDS);
   localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(OUTPUT_WORDS - 1);

   state_t           state, state_next;
   logic [CNT_W-1:0] load_limit;
   logic             load_beat, load_hit;
   logic             rd_hit, sent_hit;
   logic             m_accept, drain_end;
   logic             pending;

   assign load_beat = s.valid && s.ready;
   assign m_accept  = (state == ST_DRAIN) && m.valid && m.ready;
   assign drain_end = m_accept && sent_hit;
   assign busy      = (state != ST_IDLE);

   buffer_load_sequencer_seg_counter #(.CNT_W(CNT_W)) u_load_cnt (
      .clk(clk), .reset(reset), .clear(load_beat && load_hit), .inc(load_beat),
      .limit(load_limit), .hit(load_hit)
   );

   buffer_load_sequencer_seg_counter #(.CNT_W(CNT_W)) u_rd_cnt (
      .clk(clk), .reset(reset), .clear(drain_end), .inc(out_rd_en),
      .limit(OUT_ALL), .hit(rd_hit)
   );

   buffer_load_sequencer_seg_counter #(.CNT_W(CNT_W)) u_sent_cnt (
      .clk(clk), .reset(reset), .clear(drain_end), .inc(m_accept),
      .limit(OUT_LAST), .hit(sent_hit)
   );

   // NOTE: the asynchronous reset clears every register, so an aborted pass leaves no residue.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   // NOTE: every output of this block gets a default first so no latch can be inferred.
   always_comb begin
      state_next = state;
      s.ready    = 1'b0;
      load_limit = '0;
      out_rd_en  = 1'b0;
      unique case (state)
         ST_IDLE:     if (start) state_next = ST_LOAD_IN;
         ST_LOAD_IN: begin
            s.ready    = 1'b1;
            load_limit = IN_LAST;
            if (s.valid && load_hit) state_next = ST_LOAD_WT;
         end
         ST_LOAD_WT: begin
            s.ready    = 1'b1;
            load_limit = WT_LAST;
            if (s.valid && load_hit) state_next = ST_LOAD_IDX;
         end
         ST_LOAD_IDX: begin
            s.ready    = 1'b1;
            load_limit = IDX_LAST;
            if (s.valid && load_hit) state_next = ST_COMPUTE;
         end
         // compute_start is high only in the first COMPUTE cycle, masking compute_done there.
         ST_COMPUTE:  if (!compute_start && compute_done) state_next = ST_DRAIN;
         ST_DRAIN: begin
            out_rd_en = !rd_hit && !pending && (!m.valid || m.ready);
            if (drain_end) state_next = ST_IDLE;
         end
         default:     state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_wr_en      <= 1'b0;
         wt_wr_en      <= 1'b0;
         idx_wr_en     <= 1'b0;
         buf_wr_data   <= '0;
         compute_start <= 1'b0;
         pending       <= 1'b0;
         done          <= 1'b0;
         m.data        <= '0;
         m.valid       <= 1'b0;
      end else begin
         in_wr_en      <= load_beat && (state == ST_LOAD_IN);
         wt_wr_en      <= load_beat && (state == ST_LOAD_WT);
         idx_wr_en     <= load_beat && (state == ST_LOAD_IDX);
         if (load_beat) buf_wr_data <= s.data;
         compute_start <= (state_next == ST_COMPUTE) && (state != ST_COMPUTE);
         pending       <= out_rd_en;
         done          <= drain_end;
         // A read is only issued when the output slot is free by the time its data returns.
         if (pending) begin
            m.data  <= out_rd_data;
            m.valid <= 1'b1;
         end else if (m_accept) begin
            m.valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_buffer_load_sequencer.sv
// Self-checking bench for buffer_load_sequencer: table-driven passes with a write/output scoreboard.
module tb_buffer_load_sequencer;
   localparam int DW    = 32;
   localparam int INW   = 2;
   localparam int WTW   = 2;
   localparam int IXW   = 1;
   localparam int OUTW  = 2;
   localparam int CW    = 16;
   localparam int LOADW = INW + WTW + IXW;
   localparam logic [DW-1:0] JUNK = 32'hDEAD_BEEF;

   typedef struct {
      logic [3:0]    valid_pat;
      logic [7:0]    ready_pat;
      int            done_delay;
      logic [DW-1:0] din_base;
      logic [DW-1:0] dout0;
      logic [DW-1:0] dout1;
      bit            start_in_wt;
      bit            done_in_load;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          in_wr_en, wt_wr_en, idx_wr_en;
   logic [DW-1:0] buf_wr_data;
   logic          compute_start;
   logic          compute_done;
   logic          out_rd_en;
   logic [DW-1:0] out_rd_data;
   logic          busy, done;

   buffer_load_sequencer_if #(.DATA_W(DW)) s_if ();
   buffer_load_sequencer_if #(.DATA_W(DW)) m_if ();

   buffer_load_sequencer #(
      .DATA_W(DW), .INPUT_WORDS(INW), .WEIGHT_WORDS(WTW), .INDEX_WORDS(IXW),
      .OUTPUT_WORDS(OUTW), .CNT_W(CW)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .s(s_if),
      .in_wr_en(in_wr_en), .wt_wr_en(wt_wr_en), .idx_wr_en(idx_wr_en),
      .buf_wr_data(buf_wr_data), .compute_start(compute_start), .compute_done(compute_done),
      .out_rd_en(out_rd_en), .out_rd_data(out_rd_data), .m(m_if),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [DW+2:0] wr_q [$];
   logic [DW-1:0] m_q [$];
   vec_t vecs [5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_ctrl"}, 64'({busy, s_if.ready, in_wr_en, wt_wr_en, idx_wr_en,
                                  compute_start, out_rd_en, done, m_if.valid}), 64'(0));
      check({name, "_data"}, 64'({buf_wr_data, m_if.data}), 64'(0));
   endtask

   task automatic run_pass(input vec_t v);
      logic [DW-1:0] mem [2];
      logic [DW+2:0] exp_wr;
      logic [DW-1:0] exp_m, prev_data;
      int  beats, reads, sends, cs_cnt, comp_at, drain_at, idx_cyc;
      bit  finished, rd_last, accept_last, prev_stall, exp_ready, in_drain, exp_done;
      mem[0] = v.dout0;
      mem[1] = v.dout1;
      beats = 0; reads = 0; sends = 0; cs_cnt = 0;
      comp_at = -1; drain_at = -1; idx_cyc = -1;
      finished = 0; rd_last = 0; accept_last = 0; prev_stall = 0; prev_data = '0;
      wr_q.delete();
      m_q.delete();
      for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
         @(negedge clk);
         // Registered outputs from the last edge.
         if (wr_q.size() > 0) begin
            exp_wr = wr_q.pop_front();
            check("buf_write", 64'({in_wr_en, wt_wr_en, idx_wr_en, buf_wr_data}), 64'(exp_wr));
         end else begin
            check("no_write", 64'({in_wr_en, wt_wr_en, idx_wr_en}), 64'(0));
         end
         if (compute_start) begin
            cs_cnt++;
            if (comp_at < 0) begin
               comp_at  = cyc;
               drain_at = cyc + ((v.done_delay > 1) ? v.done_delay : 1) + 1;
            end
         end
         exp_done = accept_last && (sends == OUTW);
         check("done_pulse", 64'(done), 64'(exp_done));
         if (exp_done) begin
            check("idle_after_pass", 64'({busy, m_if.valid}), 64'(0));
            finished = 1;
         end
         if (prev_stall) begin
            check("hold_valid", 64'(m_if.valid), 64'(1));
            check("hold_data", 64'(m_if.data), 64'(prev_data));
         end
         // Drive this cycle's inputs.
         out_rd_data  = (rd_last && reads <= OUTW) ? mem[reads-1] : JUNK;
         in_drain     = (drain_at >= 0) && (cyc >= drain_at);
         exp_ready    = (cyc >= 1) && (beats < LOADW);
         start        = (cyc == 0) || (v.start_in_wt && beats >= INW && beats < INW + WTW);
         s_if.valid   = exp_ready && v.valid_pat[cyc % 4];
         s_if.data    = v.din_base + DW'(beats);
         compute_done = (v.done_in_load && cyc >= 1 && beats < INW) ||
                        (comp_at >= 0 && cyc - comp_at >= v.done_delay);
         m_if.ready   = in_drain ? v.ready_pat[(cyc - drain_at) % 8] : 1'b0;
         #1;
         check("s_ready", 64'(s_if.ready), 64'(exp_ready));
         if (exp_ready && s_if.valid) begin
            wr_q.push_back({(beats < INW) ? 3'b100 : (beats < INW + WTW) ? 3'b010 : 3'b001,
                            s_if.data});
            if (beats == LOADW - 1) idx_cyc = cyc;
            beats++;
         end
         if (cyc == drain_at) check("drain_entry_read", 64'(out_rd_en), 64'(1));
         rd_last = out_rd_en;
         if (out_rd_en) begin
            check("read_window", 64'(in_drain && reads < OUTW), 64'(1));
            if (reads < OUTW) m_q.push_back(mem[reads]);
            reads++;
         end
         accept_last = m_if.valid && m_if.ready;
         if (accept_last) begin
            if (m_q.size() > 0) begin
               exp_m = m_q.pop_front();
               check("m_data", 64'(m_if.data), 64'(exp_m));
            end else begin
               check("unexpected_m_beat", 64'(m_if.valid), 64'(0));
            end
            sends++;
         end
         prev_stall = m_if.valid && !m_if.ready;
         prev_data  = m_if.data;
         if (prev_stall) check("no_read_while_stalled", 64'(out_rd_en), 64'(0));
      end
      check("pass_completed", 64'(finished), 64'(1));
      check("compute_start_pulses", 64'(cs_cnt), 64'(1));
      check("compute_start_timing", 64'(comp_at), 64'(idx_cyc + 1));
      check("read_count", 64'(reads), 64'(OUTW));
      start = 1'b0; s_if.valid = 1'b0; compute_done = 1'b0; m_if.ready = 1'b0; out_rd_data = JUNK;
      @(negedge clk);
      check("start_not_queued", 64'(busy), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1);
   end

   initial begin
      // {valid_pat, ready_pat, done_delay, din_base, dout0, dout1, start_in_wt, done_in_load}
      vecs[0] = '{4'b1111, 8'hFF, 0, 32'h0000_00A0, 32'h0000_0055, 32'h0000_0066, 1'b0, 1'b0};
      vecs[1] = '{4'b0101, 8'hFF, 3, 32'h0000_00A0, 32'h0000_0011, 32'h0000_0022, 1'b0, 1'b0};
      vecs[2] = '{4'b1111, 8'hC0, 1, 32'h0000_0030, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0};
      vecs[3] = '{4'b0111, 8'hAA, 2, 32'h0000_0040, 32'h0000_0077, 32'h0000_0088, 1'b1, 1'b1};
      vecs[4] = '{4'b0011, 8'h55, 5, 32'h0000_00F0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0};

      reset = 1'b1; start = 1'b0; compute_done = 1'b0; out_rd_data = JUNK;
      s_if.valid = 1'b0; s_if.data = '0; m_if.ready = 1'b0;
      #2;
      check_all_zero("reset_state");
      @(negedge clk);
      reset = 1'b0;

      // Idle must ignore stream data, compute_done and m_ready without a start.
      s_if.valid = 1'b1; s_if.data = 32'h1111_1111; compute_done = 1'b1; m_if.ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         check("idle_quiet", 64'({busy, s_if.ready, in_wr_en, wt_wr_en, idx_wr_en,
                                  compute_start, out_rd_en, done}), 64'(0));
      end
      s_if.valid = 1'b0; compute_done = 1'b0; m_if.ready = 1'b0;

      for (int i = 0; i < 5; i++) run_pass(vecs[i]);

      // Asynchronous reset in the middle of LOAD_WT, then a clean restart.
      @(negedge clk);
      start = 1'b1; s_if.valid = 1'b1; s_if.data = 32'h0000_0099;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_reset_in_load_wt", 64'({busy, wt_wr_en}), 64'(2'b11));
      #2 reset = 1'b1;
      #1;
      check_all_zero("mid_pass_reset");
      @(negedge clk);
      reset = 1'b0;
      s_if.valid = 1'b0;
      run_pass(vecs[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
